// File: rtl/fifo2axis_pkg.sv
// Shared definitions for the FIFO-to-AXIS width converter.
// - clogb2: width needed to hold values 0..value-1 (minimum 1)
// - pacer_state_e: line pacer FSM states
// - lane_lsb: bit offset of a beat lane inside a FIFO word, honouring beat order
package fifo2axis_pkg;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StArmed = 1'b1
  } pacer_state_e;

  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned width;
    width = 1;
    while ((64'd1 << width) < 64'(value)) width++;
    return width;
  endfunction

  // Lane 0 is the first beat emitted from a word.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned ratio,
                                           input int unsigned beat_w, input bit msb_first);
    return msb_first ? (ratio - 1 - lane) * beat_w : lane * beat_w;
  endfunction

endpackage

// File: rtl/fifo2axis_wc_if.sv
// Bundle of the converter's stream, FIFO and status signals.
// master: converter side (drives M_AXIS_* except TREADY, brd_rdy, err_*).
// slave:  environment side (snooped input stream, sink ready, FIFO head/status).
interface fifo2axis_wc_if #(
  parameter int unsigned FDW             = 128,
  parameter int unsigned FAW             = 8,
  parameter int unsigned AXIS_DATA_WIDTH = 32
) ();
  logic                         S_AXIS_TVALID;
  logic                         S_AXIS_TLAST;
  logic                         M_AXIS_TVALID;
  logic [AXIS_DATA_WIDTH-1:0]   M_AXIS_TDATA;
  logic [AXIS_DATA_WIDTH/8-1:0] M_AXIS_TSTRB;
  logic                         M_AXIS_TLAST;
  logic                         M_AXIS_TUSER;
  logic                         M_AXIS_TREADY;
  logic                         brd_rdy;
  logic                         brd_vld;
  logic [FDW-1:0]               brd_din;
  logic                         brd_empty;
  logic [FAW:0]                 brd_cnt;
  logic                         err_overrun;
  logic                         err_underrun;

  modport master (
    input  S_AXIS_TVALID, S_AXIS_TLAST, M_AXIS_TREADY, brd_vld, brd_din, brd_empty, brd_cnt,
    output M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TLAST, M_AXIS_TUSER, brd_rdy,
           err_overrun, err_underrun
  );

  modport slave (
    output S_AXIS_TVALID, S_AXIS_TLAST, M_AXIS_TREADY, brd_vld, brd_din, brd_empty, brd_cnt,
    input  M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TLAST, M_AXIS_TUSER, brd_rdy,
           err_overrun, err_underrun
  );
endinterface

// File: rtl/axis_line_pacer.sv
// Line pacer: snoops input end-of-line events, waits FRAME_DELAY input frames, then
// grants one output-line credit per input line.
// Ports: clk_i/rst_i (async active-high), in_eol_i (input TVALID&&TLAST),
//        out_last_i (output TLAST handshake), armed_o, credit_nz_o, err_overrun_o (sticky).
module axis_line_pacer
  import fifo2axis_pkg::*;
#(
  parameter int unsigned LINES_PER_FRAME = 1024,
  parameter int unsigned FRAME_DELAY     = 2,
  parameter int unsigned CREDIT_W        = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic in_eol_i,
  input  logic out_last_i,
  output logic armed_o,
  output logic credit_nz_o,
  output logic err_overrun_o
);

  localparam int unsigned          LineW      = clogb2(LINES_PER_FRAME);
  localparam logic [LineW-1:0]     LastLine   = LineW'(LINES_PER_FRAME - 1);
  localparam logic [9:0]           FrameDelay = 10'(FRAME_DELAY);
  localparam logic [CREDIT_W-1:0]  CreditMax  = '1;

  pacer_state_e        state_q;
  logic [LineW-1:0]    in_line_q;
  logic [9:0]          in_frame_q;
  logic [CREDIT_W-1:0] credit_q;
  logic                overrun_q;

  logic line_wrap, arm, credit_inc, credit_dec;

  assign line_wrap  = in_eol_i && (in_line_q == LastLine);
  // The eol that completes the last delay frame both arms and grants the first credit.
  assign arm        = (state_q == StIdle) && line_wrap && (in_frame_q == FrameDelay - 10'd1);
  assign credit_inc = arm || ((state_q == StArmed) && in_eol_i);
  assign credit_dec = out_last_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      in_line_q  <= '0;
      in_frame_q <= '0;
      credit_q   <= '0;
      overrun_q  <= 1'b0;
    end else begin
      if (in_eol_i) in_line_q <= line_wrap ? '0 : in_line_q + 1'b1;
      if (line_wrap && (in_frame_q != FrameDelay)) in_frame_q <= in_frame_q + 10'd1;

      case (state_q)
        StIdle:  if (arm) state_q <= StArmed;
        StArmed: state_q <= StArmed;
        default: state_q <= StIdle;
      endcase

      case ({credit_inc, credit_dec})
        2'b10: begin
          if (credit_q == CreditMax) overrun_q <= 1'b1;
          else                       credit_q  <= credit_q + 1'b1;
        end
        2'b01:   credit_q <= credit_q - 1'b1;
        default: ;
      endcase
    end
  end

  assign armed_o       = (state_q == StArmed);
  assign credit_nz_o   = (credit_q != '0);
  assign err_overrun_o = overrun_q;

endmodule

// File: rtl/fifo2axis_wc.sv
// FIFO-to-AXIS width converter. Pops FDW-bit words from a FWFT FIFO and emits each as
// FDW/AXIS_DATA_WIDTH beats, with TLAST per line and TUSER on the first beat of a frame.
// Line release is paced by axis_line_pacer.
// Ports: M_AXIS_ACLK, M_AXIS_ARESET (async active-high), axis_io (master modport: snooped
//        input stream, AXIS master, FIFO pop handshake, sticky error flags).
module fifo2axis_wc
  import fifo2axis_pkg::*;
#(
  parameter int unsigned FDW             = 128,
  parameter int unsigned FAW             = 8,
  parameter int unsigned AXIS_DATA_WIDTH = 32,
  parameter int unsigned BEATS_PER_LINE  = 320,
  parameter int unsigned LINES_PER_FRAME = 1024,
  parameter int unsigned FRAME_DELAY     = 2,
  parameter bit          MSB_FIRST       = 1'b1,
  parameter int unsigned CREDIT_W        = 4
) (
  input  logic           M_AXIS_ACLK,
  input  logic           M_AXIS_ARESET,
  fifo2axis_wc_if.master axis_io
);

  localparam int unsigned      Ratio    = FDW / AXIS_DATA_WIDTH;
  localparam int unsigned      LaneW    = clogb2(Ratio);
  localparam int unsigned      BeatW    = clogb2(BEATS_PER_LINE);
  localparam int unsigned      LineW    = clogb2(LINES_PER_FRAME);
  localparam int unsigned      OffW     = clogb2(FDW);
  localparam logic [LaneW-1:0] LastLane = LaneW'(Ratio - 1);
  localparam logic [BeatW-1:0] LastBeat = BeatW'(BEATS_PER_LINE - 1);
  localparam logic [LineW-1:0] LastLine = LineW'(LINES_PER_FRAME - 1);

  logic [FDW-1:0]   hold_q;
  logic             hold_vld_q;
  logic [LaneW-1:0] lane_q;
  logic [BeatW-1:0] beat_q;
  logic [LineW-1:0] line_q;
  logic             underrun_q;
  logic             credit_nz_prev_q;
  logic             last_hs_prev_q;

  logic armed, credit_nz;
  logic tvalid, accept, last_lane, brd_rdy, pop, tlast_pos, last_hs;
  logic underrun_eval, underrun_cond;
  logic [OffW-1:0] lane_off;

  // FIFO status is informational only.
  logic         unused_empty;
  logic [FAW:0] unused_cnt;
  assign unused_empty = axis_io.brd_empty;
  assign unused_cnt   = axis_io.brd_cnt;

  axis_line_pacer #(
    .LINES_PER_FRAME(LINES_PER_FRAME),
    .FRAME_DELAY    (FRAME_DELAY),
    .CREDIT_W       (CREDIT_W)
  ) u_pacer (
    .clk_i        (M_AXIS_ACLK),
    .rst_i        (M_AXIS_ARESET),
    .in_eol_i     (axis_io.S_AXIS_TVALID && axis_io.S_AXIS_TLAST),
    .out_last_i   (last_hs),
    .armed_o      (armed),
    .credit_nz_o  (credit_nz),
    .err_overrun_o(axis_io.err_overrun)
  );

  assign tvalid    = armed && hold_vld_q && credit_nz;
  assign accept    = tvalid && axis_io.M_AXIS_TREADY;
  assign last_lane = (lane_q == LastLane);
  // Refill on the last-lane accept so consecutive words stream without a bubble.
  assign brd_rdy   = armed && (!hold_vld_q || (last_lane && accept));
  assign pop       = brd_rdy && axis_io.brd_vld;
  assign tlast_pos = (beat_q == LastBeat);
  assign last_hs   = accept && tlast_pos;

  // Underrun is only judged when a line has just become due.
  assign underrun_eval = credit_nz && (!credit_nz_prev_q || last_hs_prev_q);
  assign underrun_cond = (beat_q == '0) && !hold_vld_q && !axis_io.brd_vld;

  assign lane_off = OffW'(lane_lsb(32'(lane_q), Ratio, AXIS_DATA_WIDTH, MSB_FIRST));

  always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
    if (M_AXIS_ARESET) begin
      hold_q           <= '0;
      hold_vld_q       <= 1'b0;
      lane_q           <= '0;
      beat_q           <= '0;
      line_q           <= '0;
      underrun_q       <= 1'b0;
      credit_nz_prev_q <= 1'b0;
      last_hs_prev_q   <= 1'b0;
    end else begin
      if (pop) begin
        hold_q     <= axis_io.brd_din;
        hold_vld_q <= 1'b1;
        lane_q     <= '0;
      end else if (accept) begin
        if (last_lane) hold_vld_q <= 1'b0;
        else           lane_q     <= lane_q + 1'b1;
      end

      if (accept) begin
        if (tlast_pos) begin
          beat_q <= '0;
          line_q <= (line_q == LastLine) ? '0 : line_q + 1'b1;
        end else begin
          beat_q <= beat_q + 1'b1;
        end
      end

      credit_nz_prev_q <= credit_nz;
      last_hs_prev_q   <= last_hs;
      if (underrun_eval && underrun_cond) underrun_q <= 1'b1;
    end
  end

  // Markers are gated by TVALID so they read 0 whenever no beat is offered.
  assign axis_io.M_AXIS_TVALID = tvalid;
  assign axis_io.M_AXIS_TDATA  = hold_q[lane_off +: AXIS_DATA_WIDTH];
  assign axis_io.M_AXIS_TSTRB  = '1;
  assign axis_io.M_AXIS_TLAST  = tvalid && tlast_pos;
  assign axis_io.M_AXIS_TUSER  = tvalid && (beat_q == '0) && (line_q == '0);
  assign axis_io.brd_rdy       = brd_rdy;
  assign axis_io.err_underrun  = underrun_q;

endmodule

// File: tb/tb_fifo2axis_wc.sv
// Self-checking bench: two converters (MSB-first and LSB-first) driven with identical
// stimulus; a FIFO model per instance and a beat-index scoreboard derived from line/frame
// arithmetic.
module tb_fifo2axis_wc;

  localparam int unsigned FDW   = 128;
  localparam int unsigned FAW   = 8;
  localparam int unsigned DW    = 32;
  localparam int unsigned BPL   = 8;
  localparam int unsigned LPF   = 4;
  localparam int unsigned FD    = 2;
  localparam int unsigned CW    = 4;
  localparam int unsigned RATIO = FDW / DW;
  localparam int unsigned MAXW  = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo2axis_wc_if #(.FDW(FDW), .FAW(FAW), .AXIS_DATA_WIDTH(DW)) bus0 ();
  fifo2axis_wc_if #(.FDW(FDW), .FAW(FAW), .AXIS_DATA_WIDTH(DW)) bus1 ();

  fifo2axis_wc #(
    .FDW(FDW), .FAW(FAW), .AXIS_DATA_WIDTH(DW), .BEATS_PER_LINE(BPL),
    .LINES_PER_FRAME(LPF), .FRAME_DELAY(FD), .MSB_FIRST(1'b1), .CREDIT_W(CW)
  ) dut0 (
    .M_AXIS_ACLK  (clk),
    .M_AXIS_ARESET(rst),
    .axis_io      (bus0)
  );

  fifo2axis_wc #(
    .FDW(FDW), .FAW(FAW), .AXIS_DATA_WIDTH(DW), .BEATS_PER_LINE(BPL),
    .LINES_PER_FRAME(LPF), .FRAME_DELAY(FD), .MSB_FIRST(1'b0), .CREDIT_W(CW)
  ) dut1 (
    .M_AXIS_ACLK  (clk),
    .M_AXIS_ARESET(rst),
    .axis_io      (bus1)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [FDW-1:0] words [MAXW];
  int   nwords;
  bit   fifo_en;
  bit   silent;
  bit   rnd_rdy;

  // Monitor-owned state, one slot per instance.
  int          nb         [2];
  int          lines_done [2];
  int          pops       [2];
  int          since      [2];
  bit          first      [2];
  bit          prev_stall [2];
  logic [DW-1:0] prev_data [2];
  logic        prev_last  [2];
  logic        prev_user  [2];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FDW-1:0] mkword(input int i);
    logic [FDW-1:0] w;
    if (i == 0) return 128'h33333333_22222222_11111111_00000000;
    for (int j = 0; j < int'(RATIO); j++) begin
      if (i < 8) w[j*DW +: DW] = {16'hA000 + 16'(i), 16'(j)};
      else       w[j*DW +: DW] = $urandom;
    end
    return w;
  endfunction

  // Beat b of the stream is lane (b % RATIO) of word (b / RATIO); instance 0 emits the
  // most significant lane first.
  function automatic logic [DW-1:0] exp_beat(input int k, input int b);
    logic [FDW-1:0] w;
    int lane, sel;
    if (b / int'(RATIO) >= nwords) return '0;
    w    = words[b / int'(RATIO)];
    lane = b % int'(RATIO);
    sel  = (k == 0) ? int'(RATIO) - 1 - lane : lane;
    return w[sel*DW +: DW];
  endfunction

  task automatic mon(input int k, input logic tv, input logic tr, input logic [DW-1:0] td,
                     input logic tl, input logic tu, input logic br, input logic bv);
    int b, n;
    if (rst) begin
      nb[k] = 0; lines_done[k] = 0; pops[k] = 0; since[k] = 0; first[k] = 1'b1;
      prev_stall[k] = 1'b0;
      return;
    end
    if (silent) begin
      chk($sformatf("dut%0d silent tvalid", k), tv, 1'b0);
      chk($sformatf("dut%0d silent brd_rdy", k), br, 1'b0);
    end
    if (prev_stall[k]) begin
      chk($sformatf("dut%0d stall tvalid", k), tv, 1'b1);
      chk($sformatf("dut%0d stall tdata", k), td, prev_data[k]);
      chk($sformatf("dut%0d stall tlast", k), tl, prev_last[k]);
      chk($sformatf("dut%0d stall tuser", k), tu, prev_user[k]);
    end
    b = nb[k];
    if (tv) begin
      chk($sformatf("dut%0d tdata beat %0d", k, b), td, exp_beat(k, b));
      chk($sformatf("dut%0d tlast beat %0d", k, b), tl, (b % int'(BPL)) == int'(BPL) - 1);
      chk($sformatf("dut%0d tuser beat %0d", k, b), tu, (b % int'(BPL * LPF)) == 0);
    end
    if (tv && tr) begin
      nb[k]++;
      if ((b % int'(BPL)) == int'(BPL) - 1) lines_done[k]++;
    end
    n = since[k] + ((tv && tr) ? 1 : 0);
    if (br && bv) begin
      chk($sformatf("dut%0d accepts per pop", k), n, first[k] ? 0 : int'(RATIO));
      since[k] = 0; first[k] = 1'b0; pops[k]++;
    end else begin
      since[k] = n;
    end
    prev_stall[k] = tv && !tr;
    prev_data[k]  = td;
    prev_last[k]  = tl;
    prev_user[k]  = tu;
  endtask

  always @(negedge clk) begin
    mon(0, bus0.M_AXIS_TVALID, bus0.M_AXIS_TREADY, bus0.M_AXIS_TDATA, bus0.M_AXIS_TLAST,
        bus0.M_AXIS_TUSER, bus0.brd_rdy, bus0.brd_vld);
    mon(1, bus1.M_AXIS_TVALID, bus1.M_AXIS_TREADY, bus1.M_AXIS_TDATA, bus1.M_AXIS_TLAST,
        bus1.M_AXIS_TUSER, bus1.brd_rdy, bus1.brd_vld);
  end

  task automatic refresh();
    bus0.brd_vld   = fifo_en && (pops[0] < nwords);
    bus0.brd_din   = (pops[0] < nwords) ? words[pops[0]] : '0;
    bus0.brd_empty = !(pops[0] < nwords);
    bus0.brd_cnt   = (FAW + 1)'(nwords - pops[0]);
    bus1.brd_vld   = fifo_en && (pops[1] < nwords);
    bus1.brd_din   = (pops[1] < nwords) ? words[pops[1]] : '0;
    bus1.brd_empty = !(pops[1] < nwords);
    bus1.brd_cnt   = (FAW + 1)'(nwords - pops[1]);
  endtask

  task automatic set_rdy(input logic r);
    bus0.M_AXIS_TREADY = r;
    bus1.M_AXIS_TREADY = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) set_rdy(1'($urandom_range(0, 1)));
    refresh();
  endtask

  task automatic set_s(input logic tv, input logic tl);
    bus0.S_AXIS_TVALID = tv; bus0.S_AXIS_TLAST = tl;
    bus1.S_AXIS_TVALID = tv; bus1.S_AXIS_TLAST = tl;
  endtask

  task automatic push(input int n);
    for (int i = 0; i < n; i++) begin
      words[nwords] = mkword(nwords);
      nwords++;
    end
    refresh();
  endtask

  // n input lines; a TVALID-only cycle precedes each eol. Silence is lifted right after
  // the eol that should arm the pacer when arm_last is set.
  task automatic eols(input int n, input bit arm_last, input int gap);
    for (int i = 0; i < n; i++) begin
      set_s(1'b1, 1'b0); tick();
      set_s(1'b1, 1'b1); tick();
      set_s(1'b0, 1'b1);
      if (arm_last && i == n - 1) silent = 1'b0;
      if (i < n - 1) for (int g = 0; g < gap; g++) tick();
    end
    set_s(1'b0, 1'b0);
  endtask

  task automatic wait_lines(input int target, input int budget);
    int c;
    c = 0;
    while ((lines_done[0] < target || lines_done[1] < target) && c < budget) begin
      tick();
      c++;
    end
    chk("dut0 lines emitted", lines_done[0], target);
    chk("dut1 lines emitted", lines_done[1], target);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    silent = 1'b1; rnd_rdy = 1'b0; fifo_en = 1'b1; nwords = 0;
    set_s(1'b0, 1'b0);
    set_rdy(1'b1);
    refresh();
    tick(); tick();
    rst = 1'b0;
    refresh();
  endtask

  initial begin
    rst = 1'b1; silent = 1'b1; rnd_rdy = 1'b0; fifo_en = 1'b1; nwords = 0;
    set_s(1'b0, 1'b0);
    set_rdy(1'b0);
    refresh();
    tick(); tick(); tick();

    // Reset state
    chk("rst tvalid", bus0.M_AXIS_TVALID, 1'b0);
    chk("rst tdata", bus0.M_AXIS_TDATA, '0);
    chk("rst tstrb", bus0.M_AXIS_TSTRB, 4'hf);
    chk("rst tlast", bus0.M_AXIS_TLAST, 1'b0);
    chk("rst tuser", bus0.M_AXIS_TUSER, 1'b0);
    chk("rst brd_rdy", bus0.brd_rdy, 1'b0);
    chk("rst overrun", bus0.err_overrun, 1'b0);
    chk("rst underrun", bus0.err_underrun, 1'b0);
    chk("rst tuser lsb", bus1.M_AXIS_TUSER, 1'b0);
    rst = 1'b0;

    // Pacing: silent for 7 eols, one line after the 8th
    push(40);
    set_rdy(1'b1);
    eols(7, 1'b0, 3);
    for (int g = 0; g < 3; g++) tick();
    chk("no line before arm", lines_done[0], 0);
    eols(1, 1'b1, 0);
    wait_lines(1, 100);
    for (int g = 0; g < 10; g++) tick();
    chk("single credit line0", lines_done[0], 1);
    chk("idle after credit", bus0.M_AXIS_TVALID, 1'b0);

    // Random backpressure over further lines
    rnd_rdy = 1'b1;
    for (int i = 0; i < 6; i++) eols(1, 1'b0, 0);
    for (int i = 0; i < 6; i++) if (i < 0) tick();
    wait_lines(7, 3000);
    rnd_rdy = 1'b0;
    set_rdy(1'b1);
    chk("random underrun0", bus0.err_underrun, 1'b0);
    chk("random overrun0", bus0.err_overrun, 1'b0);
    chk("random underrun1", bus1.err_underrun, 1'b0);

    // Credit saturation with the sink stalled
    do_reset();
    push(32);
    set_rdy(1'b0);
    eols(8, 1'b1, 1);
    eols(14, 1'b0, 1);
    tick();
    chk("overrun before 16th credit", bus0.err_overrun, 1'b0);
    eols(1, 1'b0, 0);
    tick();
    chk("overrun set dut0", bus0.err_overrun, 1'b1);
    chk("overrun set dut1", bus1.err_overrun, 1'b1);
    set_rdy(1'b1);
    wait_lines(15, 1000);
    for (int g = 0; g < 30; g++) tick();
    chk("exactly 15 lines", lines_done[0], 15);
    chk("stopped after 15", bus0.M_AXIS_TVALID, 1'b0);
    chk("no underrun on saturation", bus0.err_underrun, 1'b0);

    // Credit granted with the FIFO empty
    do_reset();
    fifo_en = 1'b0;
    push(4);
    eols(8, 1'b1, 1);
    for (int g = 0; g < 5; g++) tick();
    chk("underrun set dut0", bus0.err_underrun, 1'b1);
    chk("underrun set dut1", bus1.err_underrun, 1'b1);
    chk("underrun tvalid", bus0.M_AXIS_TVALID, 1'b0);
    fifo_en = 1'b1;
    refresh();
    wait_lines(1, 100);

    // Reset in the middle of a line
    do_reset();
    push(8);
    eols(8, 1'b1, 1);
    for (int c = 0; c < 50 && nb[0] != 3; c++) tick();
    chk("reached beat 3", nb[0], 3);
    rst = 1'b1;
    #1;
    chk("midrst tvalid0", bus0.M_AXIS_TVALID, 1'b0);
    chk("midrst tdata0", bus0.M_AXIS_TDATA, '0);
    chk("midrst tlast0", bus0.M_AXIS_TLAST, 1'b0);
    chk("midrst tuser0", bus0.M_AXIS_TUSER, 1'b0);
    chk("midrst brd_rdy0", bus0.brd_rdy, 1'b0);
    chk("midrst tvalid1", bus1.M_AXIS_TVALID, 1'b0);
    chk("midrst tdata1", bus1.M_AXIS_TDATA, '0);
    do_reset();
    push(8);
    eols(7, 1'b0, 2);
    for (int g = 0; g < 10; g++) tick();
    chk("rearm silent", lines_done[0], 0);
    eols(1, 1'b1, 0);
    wait_lines(1, 100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
